// File: rtl/change_dispenser.sv
// change_dispenser: pays decoded change out as fewest 5 / 1 / 0.5 yuan coins over a req/ack ejector handshake
// Ports: clk, reset (async, active-high); fin/charge start a payout of the coded amount;
// eject_req/eject_sel/eject_ack form the ejector handshake (sel 00=0.5, 01=1, 10=5 yuan);
// busy/done/fault report status; remaining/paid track the payout in half-yuan units.
module change_dispenser #(
   parameter int GAP_CYCLES  = 4,
   parameter int ACK_TIMEOUT = 1000
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       fin,
   input  logic [3:0] charge,
   input  logic       eject_ack,
   output logic       eject_req,
   output logic [1:0] eject_sel,
   output logic       busy,
   output logic       done,
   output logic       fault,
   output logic [4:0] remaining,
   output logic [4:0] paid
);
   localparam int GW = $clog2(GAP_CYCLES + 2);
   localparam int TW = $clog2(ACK_TIMEOUT + 1);
   typedef enum logic [2:0] {IDLE, LOAD, REQ, GAP, DONE, FAULT} state_t;
   state_t state, state_nx;
   logic fin_d;
   logic [GW-1:0] gap_cnt, gap_nx;
   logic [TW-1:0] to_cnt, to_nx;
   logic eject_req_nx, busy_nx, done_nx, fault_nx, illegal;
   logic [1:0] eject_sel_nx, sel_rem;
   logic [4:0] remaining_nx, paid_nx, dec, coin;
   always_comb begin
      dec = 5'd0;
      illegal = 1'b0;
      case (charge)
         4'd0:    dec = 5'd0;
         4'd1:    dec = 5'd2;
         4'd2:    dec = 5'd4;
         4'd3:    dec = 5'd6;
         4'd4:    dec = 5'd8;
         4'd5:    dec = 5'd10;
         4'd6:    dec = 5'd1;
         4'd7:    dec = 5'd3;
         4'd8:    dec = 5'd5;
         4'd9:    dec = 5'd15;
         4'd10:   dec = 5'd20;
         default: illegal = 1'b1;
      endcase
   end
   // greedy choice: largest coin not exceeding what is still owed
   assign sel_rem = remaining >= 5'd10 ? 2'b10 : remaining >= 5'd2 ? 2'b01 : 2'b00;
   assign coin = eject_sel == 2'b10 ? 5'd10 : eject_sel == 2'b01 ? 5'd2 : 5'd1;
   always_comb begin
      state_nx = state;
      gap_nx = gap_cnt;
      to_nx = to_cnt;
      eject_req_nx = eject_req;
      eject_sel_nx = eject_sel;
      busy_nx = busy;
      done_nx = done;
      fault_nx = fault;
      remaining_nx = remaining;
      paid_nx = paid;
      case (state)
         IDLE: if (fin && !fin_d) begin
            if (illegal) begin
               fault_nx = 1'b1;
               state_nx = FAULT;
            end else begin
               remaining_nx = dec;
               paid_nx = 5'd0;
               busy_nx = 1'b1;
               state_nx = LOAD;
            end
         end
         LOAD: if (remaining == 5'd0) begin
            busy_nx = 1'b0;
            done_nx = 1'b1;
            state_nx = DONE;
         end else begin
            eject_req_nx = 1'b1;
            eject_sel_nx = sel_rem;
            to_nx = '0;
            state_nx = REQ;
         end
         REQ: if (eject_ack) begin
            eject_req_nx = 1'b0;
            remaining_nx = remaining - coin;
            paid_nx = paid + coin;
            gap_nx = GW'(GAP_CYCLES);
            state_nx = GAP;
         end else if (to_cnt == TW'(ACK_TIMEOUT - 1)) begin
            // this edge is the ACK_TIMEOUT-th since the request rose
            eject_req_nx = 1'b0;
            fault_nx = 1'b1;
            busy_nx = 1'b0;
            state_nx = FAULT;
         end else begin
            to_nx = to_cnt + 1'b1;
         end
         GAP: if (gap_cnt != '0) begin
            gap_nx = gap_cnt - 1'b1;
         end else if (!eject_ack) begin
            if (remaining == 5'd0) begin
               busy_nx = 1'b0;
               done_nx = 1'b1;
               state_nx = DONE;
            end else begin
               eject_req_nx = 1'b1;
               eject_sel_nx = sel_rem;
               to_nx = '0;
               state_nx = REQ;
            end
         end
         DONE: if (!fin) begin
            done_nx = 1'b0;
            state_nx = IDLE;
         end
         FAULT: state_nx = FAULT;
         default: state_nx = IDLE;
      endcase
   end
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state <= IDLE;
         fin_d <= 1'b0;
         gap_cnt <= '0;
         to_cnt <= '0;
         eject_req <= 1'b0;
         eject_sel <= 2'b00;
         busy <= 1'b0;
         done <= 1'b0;
         fault <= 1'b0;
         remaining <= 5'd0;
         paid <= 5'd0;
      end else begin
         state <= state_nx;
         fin_d <= fin;
         gap_cnt <= gap_nx;
         to_cnt <= to_nx;
         eject_req <= eject_req_nx;
         eject_sel <= eject_sel_nx;
         busy <= busy_nx;
         done <= done_nx;
         fault <= fault_nx;
         remaining <= remaining_nx;
         paid <= paid_nx;
      end
   end
endmodule

// File: tb/tb_change_dispenser.sv
// tb_change_dispenser: randomized and directed self-checking bench for change_dispenser
module tb_change_dispenser;
   logic clk = 1'b0;
   logic reset = 1'b1;
   logic fin = 1'b0;
   logic [3:0] charge = 4'd0;
   logic eject_ack = 1'b0;
   logic eject_req, busy, done, fault;
   logic [1:0] eject_sel;
   logic [4:0] remaining, paid;
   logic [15:0] outs;
   int checks = 0;
   int failures = 0;
   int cyc = 0;
   int dec_tab [11] = '{0, 2, 4, 6, 8, 10, 1, 3, 5, 15, 20};
   change_dispenser #(.GAP_CYCLES(4), .ACK_TIMEOUT(8)) dut (
      .clk(clk), .reset(reset), .fin(fin), .charge(charge), .eject_ack(eject_ack),
      .eject_req(eject_req), .eject_sel(eject_sel), .busy(busy), .done(done),
      .fault(fault), .remaining(remaining), .paid(paid)
   );
   assign outs = {eject_req, eject_sel, busy, done, fault, remaining, paid};
   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;
   initial begin
      #2000000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1);
   end
   task automatic start(input logic [3:0] c);
      @(negedge clk);
      fin = 1'b0;
      @(negedge clk);
      charge = c;
      fin = 1'b1;
      @(negedge clk);
   endtask
   task automatic pulse_reset;
      @(negedge clk);
      reset = 1'b1;
      fin = 1'b0;
      eject_ack = 1'b0;
      @(negedge clk);
      reset = 1'b0;
   endtask
   // serve one coin request: ack sampled d edges after req rose, ack held h extra edges
   task automatic pay(input int d, input int h, output logic [1:0] sel, output bit ok,
                      output bit stable, output int t_req);
      ok = 1'b0;
      stable = 1'b1;
      sel = 2'b11;
      t_req = -1;
      for (int i = 0; i < 60; i++) begin
         if (eject_req === 1'b1) begin
            ok = 1'b1;
            break;
         end
         @(negedge clk);
      end
      if (!ok) return;
      sel = eject_sel;
      t_req = cyc;
      repeat (d - 1) begin
         @(negedge clk);
         if (eject_req !== 1'b1 || eject_sel !== sel) stable = 1'b0;
      end
      eject_ack = 1'b1;
      @(negedge clk);
      repeat (h) @(negedge clk);
      eject_ack = 1'b0;
   endtask
   task automatic wait_done(output bit seen, output int extra);
      seen = 1'b0;
      extra = 0;
      for (int i = 0; i < 40; i++) begin
         if (done === 1'b1) begin
            seen = 1'b1;
            break;
         end
         if (eject_req === 1'b1) extra++;
         @(negedge clk);
      end
   endtask
   task automatic test_reset;
      #1;
      checks++;
      if (outs !== 16'd0) begin failures++; $display("FAIL reset_async outs=%h expected=0000", outs); end
      repeat (2) @(negedge clk);
      checks++;
      if (outs !== 16'd0) begin failures++; $display("FAIL reset_clocked outs=%h expected=0000", outs); end
      reset = 1'b0;
      repeat (2) @(negedge clk);
      checks++;
      if (outs !== 16'd0) begin failures++; $display("FAIL reset_idle outs=%h expected=0000", outs); end
   endtask
   task automatic test_code9;
      logic [1:0] sel;
      bit ok, st, seen;
      int t, extra;
      logic [1:0] exp_sel [4] = '{2'b10, 2'b01, 2'b01, 2'b00};
      int exp_paid [4] = '{10, 12, 14, 15};
      start(4'd9);
      checks++;
      if (busy !== 1'b1 || eject_req !== 1'b0) begin failures++; $display("FAIL code9_load busy=%b req=%b expected busy=1 req=0", busy, eject_req); end
      @(negedge clk);
      checks++;
      if (eject_req !== 1'b1) begin failures++; $display("FAIL code9_req_latency req=%b expected=1", eject_req); end
      for (int k = 0; k < 4; k++) begin
         pay(2, 0, sel, ok, st, t);
         checks++;
         if (!ok || sel !== exp_sel[k] || !st) begin failures++; $display("FAIL code9_sel%0d ok=%b sel=%b stable=%b expected sel=%b", k, ok, sel, st, exp_sel[k]); end
         checks++;
         if (eject_req !== 1'b0 || paid !== 5'(exp_paid[k]) || remaining !== 5'(15 - exp_paid[k])) begin
            failures++; $display("FAIL code9_paid%0d req=%b paid=%0d rem=%0d expected paid=%0d rem=%0d", k, eject_req, paid, remaining, exp_paid[k], 15 - exp_paid[k]);
         end
      end
      wait_done(seen, extra);
      checks++;
      if (!seen || extra != 0 || remaining !== 5'd0 || busy !== 1'b0) begin failures++; $display("FAIL code9_done seen=%b extra=%0d rem=%0d busy=%b expected 1/0/0/0", seen, extra, remaining, busy); end
   endtask
   task automatic test_code10;
      logic [1:0] sel;
      bit ok, st, seen;
      int t1, t2, m, extra;
      start(4'd10);
      pay(1, 0, sel, ok, st, t1);
      m = cyc;
      checks++;
      if (!ok || sel !== 2'b10 || remaining !== 5'd10 || eject_req !== 1'b0) begin failures++; $display("FAIL code10_first ok=%b sel=%b rem=%0d req=%b expected 1/10/10/0", ok, sel, remaining, eject_req); end
      pay(1, 0, sel, ok, st, t2);
      checks++;
      if (!ok || sel !== 2'b10 || t2 != m + 5) begin failures++; $display("FAIL code10_gap ok=%b sel=%b req_edge=%0d expected sel=10 edge=%0d", ok, sel, t2, m + 5); end
      wait_done(seen, extra);
      checks++;
      if (!seen || extra != 0 || paid !== 5'd20) begin failures++; $display("FAIL code10_done seen=%b extra=%0d paid=%0d expected 1/0/20", seen, extra, paid); end
   endtask
   task automatic test_code0;
      logic [1:0] sel;
      bit ok, st, seen;
      int t, extra;
      start(4'd0);
      checks++;
      if (busy !== 1'b1 || done !== 1'b0 || eject_req !== 1'b0) begin failures++; $display("FAIL code0_load busy=%b done=%b req=%b expected 1/0/0", busy, done, eject_req); end
      @(negedge clk);
      checks++;
      if (done !== 1'b1 || busy !== 1'b0 || eject_req !== 1'b0 || paid !== 5'd0) begin failures++; $display("FAIL code0_done done=%b busy=%b req=%b paid=%0d expected 1/0/0/0", done, busy, eject_req, paid); end
      @(negedge clk);
      checks++;
      if (done !== 1'b1) begin failures++; $display("FAIL code0_hold done=%b expected=1", done); end
      fin = 1'b0;
      @(negedge clk);
      checks++;
      if (done !== 1'b0) begin failures++; $display("FAIL code0_clear done=%b expected=0", done); end
      start(4'd6);
      checks++;
      if (busy !== 1'b1) begin failures++; $display("FAIL code0_rearm busy=%b expected=1", busy); end
      pay(3, 1, sel, ok, st, t);
      checks++;
      if (!ok || sel !== 2'b00 || paid !== 5'd1) begin failures++; $display("FAIL code0_rearm_pay ok=%b sel=%b paid=%0d expected 1/00/1", ok, sel, paid); end
      wait_done(seen, extra);
      checks++;
      if (!seen || extra != 0) begin failures++; $display("FAIL code0_rearm_done seen=%b extra=%0d expected 1/0", seen, extra); end
   endtask
   task automatic test_illegal;
      int reqs;
      start(4'd13);
      checks++;
      if (fault !== 1'b1 || busy !== 1'b0 || eject_req !== 1'b0) begin failures++; $display("FAIL illegal_fault fault=%b busy=%b req=%b expected 1/0/0", fault, busy, eject_req); end
      start(4'd1);
      reqs = 0;
      repeat (10) begin
         if (eject_req !== 1'b0 || busy !== 1'b0) reqs++;
         @(negedge clk);
      end
      checks++;
      if (reqs != 0 || fault !== 1'b1) begin failures++; $display("FAIL illegal_sticky active_cycles=%0d fault=%b expected 0/1", reqs, fault); end
      pulse_reset;
      checks++;
      if (outs !== 16'd0) begin failures++; $display("FAIL illegal_reset outs=%h expected=0000", outs); end
   endtask
   task automatic test_timeout;
      int k;
      start(4'd6);
      @(negedge clk);
      checks++;
      if (eject_req !== 1'b1 || eject_sel !== 2'b00) begin failures++; $display("FAIL timeout_req req=%b sel=%b expected 1/00", eject_req, eject_sel); end
      k = 0;
      while (k < 20 && fault !== 1'b1) begin
         @(negedge clk);
         k++;
      end
      checks++;
      if (k != 8 || eject_req !== 1'b0 || busy !== 1'b0) begin failures++; $display("FAIL timeout_edge edges=%0d req=%b busy=%b expected 8/0/0", k, eject_req, busy); end
      pulse_reset;
   endtask
   task automatic test_reset_mid;
      logic [1:0] sel;
      bit ok, st, seen;
      int t, extra;
      start(4'd5);
      pay(1, 0, sel, ok, st, t);
      checks++;
      if (!ok || sel !== 2'b10 || paid !== 5'd10) begin failures++; $display("FAIL rstmid_pay ok=%b sel=%b paid=%0d expected 1/10/10", ok, sel, paid); end
      reset = 1'b1;
      fin = 1'b0;
      #1;
      checks++;
      if (outs !== 16'd0) begin failures++; $display("FAIL rstmid_async outs=%h expected=0000", outs); end
      @(negedge clk);
      reset = 1'b0;
      start(4'd1);
      pay(2, 0, sel, ok, st, t);
      checks++;
      if (!ok || sel !== 2'b01 || paid !== 5'd2 || remaining !== 5'd0) begin failures++; $display("FAIL rstmid_fresh ok=%b sel=%b paid=%0d rem=%0d expected 1/01/2/0", ok, sel, paid, remaining); end
      wait_done(seen, extra);
      checks++;
      if (!seen || extra != 0) begin failures++; $display("FAIL rstmid_done seen=%b extra=%0d expected 1/0", seen, extra); end
   endtask
   task automatic test_random;
      logic [1:0] sel;
      logic [1:0] q[$];
      bit ok, st, seen, drop;
      int t, extra, code, amt, sum, cv;
      for (int it = 0; it < 24; it++) begin
         code = ($urandom_range(0, 7) == 0) ? $urandom_range(11, 15) : $urandom_range(0, 10);
         start(4'(code));
         if (code > 10) begin
            checks++;
            if (fault !== 1'b1 || busy !== 1'b0) begin failures++; $display("FAIL rnd%0d_illegal code=%0d fault=%b busy=%b expected 1/0", it, code, fault, busy); end
            pulse_reset;
            continue;
         end
         amt = dec_tab[code];
         q.delete();
         repeat (amt / 10) q.push_back(2'b10);
         repeat ((amt % 10) / 2) q.push_back(2'b01);
         repeat (amt % 2) q.push_back(2'b00);
         drop = ($urandom_range(0, 2) == 0);
         sum = 0;
         foreach (q[k]) begin
            pay($urandom_range(1, 7), $urandom_range(0, 6), sel, ok, st, t);
            if (drop) fin = 1'b0;
            cv = q[k] == 2'b10 ? 10 : q[k] == 2'b01 ? 2 : 1;
            sum += cv;
            checks++;
            if (!ok || !st || sel !== q[k] || paid !== 5'(sum) || remaining !== 5'(amt - sum)) begin
               failures++; $display("FAIL rnd%0d_coin%0d code=%0d ok=%b stable=%b sel=%b paid=%0d rem=%0d expected sel=%b paid=%0d rem=%0d", it, k, code, ok, st, sel, paid, remaining, q[k], sum, amt - sum);
            end
         end
         wait_done(seen, extra);
         checks++;
         if (!seen || extra != 0 || paid !== 5'(amt) || remaining !== 5'd0) begin failures++; $display("FAIL rnd%0d_done code=%0d seen=%b extra=%0d paid=%0d rem=%0d expected paid=%0d", it, code, seen, extra, paid, remaining, amt); end
         if (drop) begin
            @(negedge clk);
            checks++;
            if (done !== 1'b0) begin failures++; $display("FAIL rnd%0d_pulse done=%b expected=0", it, done); end
         end
      end
   endtask
   initial begin
      test_reset;
      test_code9;
      test_code10;
      test_code0;
      test_illegal;
      test_timeout;
      test_reset_mid;
      test_random;
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule

// File: doc/change_dispenser.md
# change_dispenser

Payout block for the vending controller. It takes the 4-bit change code and `fin` flag produced by the compute stage and pays the change out through a coin ejector, using a req/ack handshake. It always uses the fewest coins, breaking the amount into 5-yuan, 1-yuan and 0.5-yuan coins. It reports progress (`busy`, `remaining`, `paid`) so the seven-segment stage can show the payout.

## Interface

**Parameters**
- `GAP_CYCLES`, default 4: minimum idle cycles between two ejector requests.
- `ACK_TIMEOUT`, default 1000: cycles `eject_req` may stay high without `eject_ack` before a fault is raised.

**Ports**
- `clk`, in, 1: system clock. The block is in this single clock domain.
- `reset`, in, 1: reset, asynchronous, active-high.
- `fin`, in, 1: change ready. Level signal; stays high until the controller refreshes.
- `charge`, in, 4: change code, defined under Operation.
- `eject_ack`, in, 1: ejector has taken the requested coin.
- `eject_req`, out, 1: request ejection of one coin.
- `eject_sel`, out, 2: coin type. 00 = 0.5 yuan, 01 = 1 yuan, 10 = 5 yuan; 11 is never driven.
- `busy`, out, 1: payout in progress.
- `done`, out, 1: payout complete.
- `fault`, out, 1: illegal code or ejector timeout. Sticky until `reset`.
- `remaining`, out, 5: change still owed, in half-yuan units.
- `paid`, out, 5: change already paid out, in half-yuan units.

## Operation

**Reset values:** all outputs are 0, the state is IDLE, and all internal counters are 0.

**Change code decode** (to half-yuan units):
- codes 1–5 → 2, 4, 6, 8, 10
- 6 → 1, 7 → 3, 8 → 5, 9 → 15, 10 → 20
- 0 → 0 (no change owed)
- 11–15 → illegal

**Start condition:** a rising edge of `fin`, detected against a registered copy `fin_d`. Edges are accepted only in IDLE.

**States**
- **IDLE**
  - On a `fin` rising edge: `remaining` ← decoded value, `paid` ← 0, `busy` ← 1, go to LOAD.
  - If the code is illegal: `fault` ← 1 and go to FAULT instead.
- **LOAD**
  - If `remaining` = 0, go to DONE.
  - Otherwise, go to REQ: `eject_req` ← 1 and `eject_sel` ← the largest coin ≤ `remaining` (≥10 → 5 yuan, ≥2 → 1 yuan, else 0.5 yuan).
- **REQ**
  - Hold `eject_req` and `eject_sel` stable until `eject_ack` is sampled high.
  - On ack: `eject_req` ← 0, `remaining` ← `remaining` − coin value, `paid` ← `paid` + coin value, load the gap counter with `GAP_CYCLES`, go to GAP.
  - If the timeout counter reaches `ACK_TIMEOUT`: `eject_req` ← 0, `fault` ← 1, `busy` ← 0, go to FAULT.
- **GAP**
  - Decrement the gap counter.
  - Exit only when the counter is 0 and `eject_ack` is low:
    - to DONE if `remaining` = 0;
    - otherwise back to REQ with the next coin selected, as in LOAD.
- **DONE**
  - `busy` ← 0, `done` ← 1.
  - Stay while `fin` is high. When `fin` is low, clear `done` and go to IDLE.
- **FAULT**
  - Terminal. Only `reset` leaves this state.

**Invariant:** `remaining` + `paid` always equals the decoded value. The width is 5 bits, with a maximum of 20; neither value can overflow.

## Timing

- `fin` rises before edge N (sampled high at edge N):
  - edge N: state becomes LOAD and `busy` = 1;
  - edge N+1: `eject_req` = 1 (state REQ).
- `eject_ack` sampled high at edge M:
  - edge M: `eject_req` = 0 and `remaining`/`paid` are updated;
  - earliest next `eject_req`: edge M+`GAP_CYCLES`+1, and only if `eject_ack` is already low.
- `done` rises one edge after the last GAP exit, or one edge after LOAD when the amount owed is 0.
- Timeout: a fault is raised at the `ACK_TIMEOUT`-th edge after `eject_req` rose, with no ack seen.
- `fin` falling mid-payout is ignored. The payout finishes, then DONE lasts exactly one cycle (`done` pulses high for one cycle).
- `fin` rising edges while not in IDLE are ignored.
- `reset` mid-payout clears everything immediately, without waiting for a clock edge. The owed amount is discarded.
- `eject_ack` high while not in REQ has no effect.

## Test plan

1. **Code 9 (7.5 yuan).** Ack each request 2 cycles after it rises → coin sequence `eject_sel` = 10, 01, 01, 00; `paid` = 10, 12, 14, 15; then `done` = 1 and `remaining` = 0.
2. **Code 10, `GAP_CYCLES` = 4.** Immediate ack → exactly two 5-yuan requests; the second request rises 5 edges after the first ack.
3. **Code 0.** → no `eject_req` ever; `done` = 1 two edges after the `fin` edge. Then drop `fin` → `done` = 0 and the block accepts a new `fin` edge.
4. **Code 13.** → `fault` = 1 one edge after the `fin` edge and no request is issued. A later valid code is ignored until `reset`.
5. **Code 6, ack never given, `ACK_TIMEOUT` = 8.** → `eject_req` falls and `fault` = 1 after 8 edges; `busy` = 0.
6. **Code 5, `reset` pulsed after the first ack.** → all outputs are 0 immediately. A fresh `fin` edge with code 1 → a single 1-yuan request and `paid` = 2.
